malloc_interval_tracker: RTL

MALLOC_INTERVAL_TRACKER -- requirements
Module: malloc_interval_tracker

---
 rtl/malloc_interval_tracker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/malloc_interval_tracker.sv
// Purpose: watches the commit stream for allocator calls and emits [base, base+size-1] on the matching return.
// Latency: the terminating ret committed in cycle N gives en_write_o in cycle N+1. Abort errors also appear in N+1.
// Backpressure: none. The commit stream and the interval-buffer write are fire-and-forget.
// Ports:
//   clk_i, rst_i (async, active-high)       clock and reset
//   cfg_enable_i, cfg_malloc_addr_i         tracking enable and allocator entry address
//   commit_*_i, a0_i                        one committed instruction per valid cycle
//   en_write_o, addr_first_o, addr_last_o   interval write pulse and bounds (held between pulses)
//   busy_o, err_o, count_o                  inside-allocator flag, abnormal-event pulse, saturating emit count
module malloc_interval_tracker #(
   parameter int DEPTH_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_enable_i,
   input  logic [31:0]      cfg_malloc_addr_i,
   input  logic             commit_valid_i,
   input  logic [31:0]      commit_pc_i,
   input  logic             commit_is_call_i,
   input  logic             commit_is_ret_i,
   input  logic [31:0]      commit_target_i,
   input  logic [31:0]      a0_i,
   output logic             en_write_o,
   output logic [31:0]      addr_first_o,
   output logic [31:0]      addr_last_o,
   output logic             busy_o,
   output logic             err_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] IN_ALLOC = 2'd1;
   localparam logic [1:0] EMIT     = 2'd2;

   logic [1:0]         state;
   logic [DEPTH_W-1:0] depth;
   logic [31:0]        size;
   logic [31:0]        base;
   logic [31:0]        ret_addr;
   logic [31:0]        last_r;
   logic               ovf_r;
   logic [31:0]        first_hold;
   logic [31:0]        last_hold;
   logic [CNT_W-1:0]   count_r;
   logic               err_r;

   logic               call_v;
   logic               ret_v;
   logic               emit;
   logic [32:0]        end_sum;

   assign call_v = commit_valid_i & commit_is_call_i;
   assign ret_v  = commit_valid_i & commit_is_ret_i;

   // The 33rd bit is the carry that marks an interval running past the top of the address space.
   assign end_sum = {1'b0, a0_i} + {1'b0, size} - 33'd1;

   // Dropping the enable during EMIT must suppress the write in that same cycle, so the pulse is gated here.
   assign emit = (state == EMIT) & cfg_enable_i;

   always_comb begin
      en_write_o   = emit;
      addr_first_o = emit ? base   : first_hold;
      addr_last_o  = emit ? last_r : last_hold;
      busy_o       = (state == IN_ALLOC);
      err_o        = err_r | (emit & ovf_r);
      count_o      = (emit && !(&count_r)) ? count_r + CNT_W'(1) : count_r;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         depth      <= '0;
         size       <= '0;
         base       <= '0;
         ret_addr   <= '0;
         last_r     <= '0;
         ovf_r      <= 1'b0;
         first_hold <= '0;
         last_hold  <= '0;
         count_r    <= '0;
         err_r      <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_enable_i && call_v && commit_target_i == cfg_malloc_addr_i) begin
                  state    <= IN_ALLOC;
                  size     <= a0_i;
                  ret_addr <= commit_pc_i + 32'd4;
                  depth    <= '0;
               end
            end
            IN_ALLOC: begin
               if (!cfg_enable_i) begin
                  state <= IDLE;
               end else if (call_v) begin
                  // Any call nests, including recursion into the allocator itself.
                  if (&depth) begin
                     state <= IDLE;
                     err_r <= 1'b1;
                  end else begin
                     depth <= depth + DEPTH_W'(1);
                  end
               end else if (ret_v) begin
                  if (depth != '0) begin
                     depth <= depth - DEPTH_W'(1);
                  end else if (commit_target_i != ret_addr) begin
                     state <= IDLE;
                     err_r <= 1'b1;
                  end else if (a0_i == 32'd0 || size == 32'd0) begin
                     // Failed or empty allocation: nothing to record, and it is not an error.
                     state <= IDLE;
                  end else begin
                     state  <= EMIT;
                     base   <= a0_i;
                     ovf_r  <= end_sum[32];
                     last_r <= end_sum[32] ? 32'hFFFF_FFFF : end_sum[31:0];
                  end
               end
            end
            EMIT: begin
               // Calls committed in this cycle are deliberately not tracked.
               state <= IDLE;
               if (cfg_enable_i) begin
                  first_hold <= base;
                  last_hold  <= last_r;
                  count_r    <= count_o;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
